// File: rtl/alu_exec_stage.sv
// Integer execute stage: ADD/SUB/logic ops with a 2-entry (main + skid) output buffer to writeback.
// Optional NZCV flags output enabled by defining ALU_EXEC_FLAGS_EN.
module alu_exec_stage #(
    parameter int XLEN             = 32,
    parameter int CTRL_ADD_WIDTH   = 2,
    parameter int CTRL_LOGIC_WIDTH = 3,
    parameter int RD_W             = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        uop_is_add,
    input  logic [CTRL_ADD_WIDTH-1:0]   ctrl_adder,
    input  logic                        uop_is_logic,
    input  logic [CTRL_LOGIC_WIDTH-1:0] ctrl_logic,
    input  logic [XLEN-1:0]             rs1_data,
    input  logic [XLEN-1:0]             rs2_data,
    input  logic [11:0]                 imm,
    input  logic [RD_W-1:0]             rd_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [XLEN-1:0]             out_result,
    output logic [RD_W-1:0]             out_rd,
    output logic                        out_we,
    output logic                        illegal_uop,
    output logic [15:0]                 uop_count
`ifdef ALU_EXEC_FLAGS_EN
    ,
    output logic [3:0]                  out_flags
`endif
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_t;

    buf_state_t state, next_state;
    logic load_main, load_skid, move_skid, accept;

    logic            is_sub, use_imm, exec_legal, exec_we;
    logic [XLEN-1:0] imm_ext, b_op, b_addend, arith_res, logic_res, exec_result;

    logic [XLEN-1:0] skid_result;
    logic [RD_W-1:0] skid_rd;
    logic            skid_we;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;

    assign imm_ext  = {{(XLEN-12){imm[11]}}, imm};
    assign use_imm  = (ctrl_adder == CTRL_ADD_WIDTH'(3)) ||
                      ((ctrl_logic >= CTRL_LOGIC_WIDTH'(4)) && (ctrl_logic <= CTRL_LOGIC_WIDTH'(6)));
    assign b_op     = use_imm ? imm_ext : rs2_data;
    assign is_sub   = (ctrl_adder == CTRL_ADD_WIDTH'(2));
    assign b_addend = is_sub ? ~b_op : b_op;

    // SUB shares the adder as A + ~B + 1; the carry out is then NOT borrow.
`ifdef ALU_EXEC_FLAGS_EN
    logic [XLEN:0] arith_full;
    logic          arith_carry;
    assign arith_full  = {1'b0, rs1_data} + {1'b0, b_addend} + (XLEN+1)'(is_sub);
    assign arith_res   = arith_full[XLEN-1:0];
    assign arith_carry = arith_full[XLEN];
`else
    assign arith_res = rs1_data + b_addend + XLEN'(is_sub);
`endif

    always_comb begin
        logic_res = '0;
        case (ctrl_logic)
            CTRL_LOGIC_WIDTH'(1), CTRL_LOGIC_WIDTH'(4): logic_res = rs1_data | b_op;
            CTRL_LOGIC_WIDTH'(2), CTRL_LOGIC_WIDTH'(5): logic_res = rs1_data ^ b_op;
            CTRL_LOGIC_WIDTH'(3), CTRL_LOGIC_WIDTH'(6): logic_res = rs1_data & b_op;
            default:                                    logic_res = '0;
        endcase
    end

    assign exec_legal = (uop_is_add ^ uop_is_logic) &&
                        (uop_is_add ? (ctrl_adder != '0)
                                    : ((ctrl_logic != '0) && (ctrl_logic != CTRL_LOGIC_WIDTH'(7))));

    always_comb begin
        exec_result = '0;
        if (exec_legal)
            exec_result = uop_is_add ? arith_res : logic_res;
    end

    assign exec_we = exec_legal && (rd_in != '0);

`ifdef ALU_EXEC_FLAGS_EN
    logic [3:0] exec_flags;
    logic [3:0] skid_flags;

    always_comb begin
        exec_flags = 4'b0;
        if (exec_legal) begin
            exec_flags[3] = exec_result[XLEN-1];
            exec_flags[2] = (exec_result == '0);
            if (uop_is_add) begin
                exec_flags[1] = arith_carry;
                exec_flags[0] = (rs1_data[XLEN-1] == b_addend[XLEN-1]) &&
                                (arith_res[XLEN-1] != rs1_data[XLEN-1]);
            end
        end
    end
`endif

    always_comb begin
        next_state = state;
        load_main  = 1'b0;
        load_skid  = 1'b0;
        move_skid  = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    next_state = ONE;
                    load_main  = 1'b1;
                end
            end
            ONE: begin
                if (accept && out_ready) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    next_state = TWO;
                    load_skid  = 1'b1;
                end else if (out_ready) begin
                    next_state = EMPTY;
                end
            end
            TWO: begin
                if (out_ready) begin
                    next_state = ONE;
                    move_skid  = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    // Main entry drives the outputs directly, so it only changes on a load or skid promotion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            out_result  <= '0;
            out_rd      <= '0;
            out_we      <= 1'b0;
            skid_result <= '0;
            skid_rd     <= '0;
            skid_we     <= 1'b0;
            illegal_uop <= 1'b0;
            uop_count   <= 16'd0;
`ifdef ALU_EXEC_FLAGS_EN
            out_flags   <= 4'b0;
            skid_flags  <= 4'b0;
`endif
        end else begin
            state <= next_state;
            if (accept) begin
                uop_count <= uop_count + 16'd1;
                if (!exec_legal)
                    illegal_uop <= 1'b1;
            end
            if (load_main) begin
                out_result <= exec_result;
                out_rd     <= rd_in;
                out_we     <= exec_we;
`ifdef ALU_EXEC_FLAGS_EN
                out_flags  <= exec_flags;
`endif
            end else if (move_skid) begin
                out_result <= skid_result;
                out_rd     <= skid_rd;
                out_we     <= skid_we;
`ifdef ALU_EXEC_FLAGS_EN
                out_flags  <= skid_flags;
`endif
            end
            if (load_skid) begin
                skid_result <= exec_result;
                skid_rd     <= rd_in;
                skid_we     <= exec_we;
`ifdef ALU_EXEC_FLAGS_EN
                skid_flags  <= exec_flags;
`endif
            end
        end
    end

endmodule
